// File: rtl/fifo_read_ctrl_if.sv
// Read-port bundle of the dual-clock FIFO read controller.
// The master side issues reads and supplies the write pointer and memory data.
interface fifo_read_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 5
);
    logic                  rd_en;
    logic [PTR_WIDTH-1:0]  wr_ptr_gray;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic [PTR_WIDTH-2:0]  rd_addr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr_gray;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [PTR_WIDTH-1:0]  rd_level;
    logic                  underflow;

    modport master (
        output rd_en, wr_ptr_gray, fifo_data_out,
        input  rd_addr, rd_ptr, rd_ptr_gray, rd_data, rd_valid,
               empty, almost_empty, rd_level, underflow
    );

    modport slave (
        input  rd_en, wr_ptr_gray, fifo_data_out,
        output rd_addr, rd_ptr, rd_ptr_gray, rd_data, rd_valid,
               empty, almost_empty, rd_level, underflow
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the dual-clock FIFO: read pointers, write-pointer
// synchroniser, empty/level flags and the registered read-data stage.
module fifo_read_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int PTR_WIDTH   = $clog2(FIFO_DEPTH) + 1,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    fifo_read_ctrl_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

    function automatic logic [PTR_WIDTH-1:0] bin_to_gray(input logic [PTR_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_WIDTH-1:0] gray_to_bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Write-pointer synchroniser: one flop per stage, stage 0 samples the raw Gray bus.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [PTR_WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge rd_clk or posedge rd_rst) begin
                    if (rd_rst) q_reg <= '0;
                    else        q_reg <= bus.wr_ptr_gray;
                end
            end else begin : g_next
                always_ff @(posedge rd_clk or posedge rd_rst) begin
                    if (rd_rst) q_reg <= '0;
                    else        q_reg <= g_sync[gi-1].q_reg;
                end
            end
        end
    endgenerate

    logic [PTR_WIDTH-1:0]  wr_ptr_sync_gray;
    logic [PTR_WIDTH-1:0]  wr_ptr_sync_bin;

    assign wr_ptr_sync_gray = g_sync[SYNC_STAGES-1].q_reg;
    assign wr_ptr_sync_bin  = gray_to_bin(wr_ptr_sync_gray);

    logic [PTR_WIDTH-1:0]  rd_ptr_reg,      rd_ptr_next;
    logic [PTR_WIDTH-1:0]  rd_ptr_gray_reg, rd_ptr_gray_next;
    logic [DATA_WIDTH-1:0] rd_data_reg,     rd_data_next;
    logic                  rd_valid_reg,    rd_valid_next;
    logic                  empty_reg,       empty_next;
    logic                  underflow_reg,   underflow_next;
    logic                  rd_acc;
    logic [PTR_WIDTH-1:0]  rd_level;

    assign rd_acc = bus.rd_en & ~empty_reg;

    // Empty compares the post-read pointer so draining the last entry flags empty on that edge.
    always_comb begin
        rd_ptr_next      = rd_ptr_reg;
        rd_data_next     = rd_data_reg;
        if (rd_acc) begin
            rd_ptr_next  = rd_ptr_reg + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
            rd_data_next = bus.fifo_data_out;
        end
        rd_ptr_gray_next = bin_to_gray(rd_ptr_next);
        rd_valid_next    = rd_acc;
        empty_next       = (rd_ptr_gray_next == wr_ptr_sync_gray);
        underflow_next   = bus.rd_en & empty_reg;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_ptr_reg      <= '0;
            rd_ptr_gray_reg <= '0;
            rd_data_reg     <= '0;
            rd_valid_reg    <= 1'b0;
            empty_reg       <= 1'b1;
            underflow_reg   <= 1'b0;
        end else begin
            rd_ptr_reg      <= rd_ptr_next;
            rd_ptr_gray_reg <= rd_ptr_gray_next;
            rd_data_reg     <= rd_data_next;
            rd_valid_reg    <= rd_valid_next;
            empty_reg       <= empty_next;
            underflow_reg   <= underflow_next;
        end
    end

    // Modulo subtraction covers the wrapped case; the extra pointer bit lets a full FIFO read as DEPTH.
    assign rd_level = wr_ptr_sync_bin - rd_ptr_reg;

    assign bus.rd_addr      = rd_ptr_reg[ADDR_WIDTH-1:0];
    assign bus.rd_ptr       = rd_ptr_reg;
    assign bus.rd_ptr_gray  = rd_ptr_gray_reg;
    assign bus.rd_data      = rd_data_reg;
    assign bus.rd_valid     = rd_valid_reg;
    assign bus.empty        = empty_reg;
    assign bus.rd_level     = rd_level;
    assign bus.almost_empty = (rd_level <= PTR_WIDTH'(AE_THRESH));
    assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: count-based FIFO model plus directed scenarios
// covering reset, underflow, write visibility, level, wrap and a full drain.
module tb_fifo_read_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int PW    = 5;
    localparam int SS    = 2;
    localparam int AE    = 2;

    logic rd_clk = 1'b0;
    logic rd_rst = 1'b1;
    always #5 rd_clk = ~rd_clk;

    fifo_read_ctrl_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

    fifo_read_ctrl #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PTR_WIDTH(PW),
        .SYNC_STAGES(SS), .AE_THRESH(AE)
    ) dut (
        .rd_clk(rd_clk),
        .rd_rst(rd_rst),
        .bus(bus)
    );

    // Write side: memory, write count and its Gray encoding
    logic [DW-1:0] mem [DEPTH];
    int            wr_count = 0;
    logic [PW-1:0] wr_bin;
    assign wr_bin            = wr_count[PW-1:0];
    assign bus.wr_ptr_gray   = wr_bin ^ (wr_bin >> 1);
    assign bus.fifo_data_out = mem[bus.rd_addr];

    byte unsigned  order_q[$];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wr_word(input logic [DW-1:0] d);
        mem[wr_count % DEPTH] = d;
        order_q.push_back(d);
        wr_count++;
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #2;
    endtask

    // Model: unbounded read count, delayed view of the write count, plain FIFO rules
    int            m_rd = 0;
    int            hist[SS] = '{default: 0};
    logic [DW-1:0] m_data = '0;
    bit            m_valid = 1'b0;
    bit            m_empty = 1'b1;
    bit            m_under = 1'b0;

    initial forever begin
        int vis;
        bit acc;
        @(posedge rd_clk or posedge rd_rst);
        if (rd_rst) begin
            m_rd = 0;
            for (int i = 0; i < SS; i++) hist[i] = 0;
            m_data  = '0;
            m_valid = 1'b0;
            m_empty = 1'b1;
            m_under = 1'b0;
        end else begin
            vis     = hist[SS-1];
            acc     = bus.rd_en && !m_empty;
            m_under = bus.rd_en && m_empty;
            m_valid = acc;
            if (acc) begin
                m_data = mem[m_rd % DEPTH];
                m_rd++;
            end
            m_empty = (vis == m_rd);
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = wr_count;
        end
    end

    // Per-cycle comparison against the model
    initial begin
        int            lvl;
        int            p;
        logic [PW-1:0] prev_gray;
        prev_gray = '0;
        forever begin
            @(negedge rd_clk);
            lvl = hist[SS-1] - m_rd;
            p   = m_rd % (2 * DEPTH);
            chk("rd_ptr",       bus.rd_ptr,       p);
            chk("rd_addr",      bus.rd_addr,      m_rd % DEPTH);
            chk("rd_ptr_gray",  bus.rd_ptr_gray,  p ^ (p >> 1));
            chk("rd_valid",     bus.rd_valid,     m_valid);
            chk("rd_data",      bus.rd_data,      m_data);
            chk("empty",        bus.empty,        m_empty);
            chk("underflow",    bus.underflow,    m_under);
            chk("rd_level",     bus.rd_level,     lvl);
            chk("almost_empty", bus.almost_empty, (lvl <= AE) ? 1 : 0);
            if (rd_rst) begin
                prev_gray = '0;
            end else if (bus.rd_ptr_gray != prev_gray) begin
                chk("gray_step", $countones(bus.rd_ptr_gray ^ prev_gray), 1);
                prev_gray = bus.rd_ptr_gray;
            end
            if (bus.rd_valid && !rd_rst) begin
                if (order_q.size() == 0) begin
                    chk("order_empty_q", 1, 0);
                end else begin
                    chk("order", bus.rd_data, order_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int written;
        int got;
        int addr_wraps;
        int ptr_wraps;
        int prev_addr;
        int prev_ptr;
        int vcount;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.rd_en = 1'b0;
        rd_rst    = 1'b1;
        tick();
        tick();
        $display("reset held: empty=%0d level=%0d", bus.empty, bus.rd_level);
        chk("rst_empty",        bus.empty,        1);
        chk("rst_level",        bus.rd_level,     0);
        chk("rst_almost_empty", bus.almost_empty, 1);
        chk("rst_valid",        bus.rd_valid,     0);
        rd_rst = 1'b0;
        tick();

        // Underflow while empty
        bus.rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            $display("underflow cycle %0d: underflow=%0d rd_ptr=%0d", k, bus.underflow, bus.rd_ptr);
            chk("uf_flag",  bus.underflow, 1);
            chk("uf_ptr",   bus.rd_ptr,    0);
            chk("uf_valid", bus.rd_valid,  0);
            chk("uf_data",  bus.rd_data,   0);
        end
        bus.rd_en = 1'b0;
        tick();
        chk("uf_clear", bus.underflow, 0);

        // Write visibility and first read
        wr_word(8'hA5);
        tick();
        chk("vis_edge1_empty", bus.empty, 1);
        tick();
        chk("vis_edge2_empty", bus.empty, 1);
        tick();
        chk("vis_edge3_empty", bus.empty, 0);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        $display("first read: rd_data=%h valid=%0d rd_ptr=%0d", bus.rd_data, bus.rd_valid, bus.rd_ptr);
        chk("rd1_data",  bus.rd_data,     8'hA5);
        chk("rd1_valid", bus.rd_valid,    1);
        chk("rd1_ptr",   bus.rd_ptr,      1);
        chk("rd1_gray",  bus.rd_ptr_gray, 1);
        chk("rd1_empty", bus.empty,       1);
        tick();
        chk("rd1_valid_drop", bus.rd_valid, 0);

        // Level and almost_empty
        for (int i = 0; i < 5; i++) wr_word(8'h10 + 8'(i));
        repeat (3) tick();
        $display("level after 5 writes: %0d ae=%0d", bus.rd_level, bus.almost_empty);
        chk("lvl5",    bus.rd_level,     5);
        chk("lvl5_ae", bus.almost_empty, 0);
        bus.rd_en = 1'b1;
        repeat (3) tick();
        bus.rd_en = 1'b0;
        $display("level after 3 reads: %0d ae=%0d", bus.rd_level, bus.almost_empty);
        chk("lvl2",    bus.rd_level,     2);
        chk("lvl2_ae", bus.almost_empty, 1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 10; i++) wr_word(8'h20 + 8'(i));
        repeat (3) tick();
        bus.rd_en = 1'b1;
        repeat (3) tick();
        bus.rd_en = 1'b0;
        chk("pre_rst_ptr",   bus.rd_ptr,   7);
        chk("pre_rst_valid", bus.rd_valid, 1);
        #1 rd_rst = 1'b1;
        #1;
        $display("async reset: rd_ptr=%0d valid=%0d empty=%0d", bus.rd_ptr, bus.rd_valid, bus.empty);
        chk("arst_ptr",   bus.rd_ptr,       0);
        chk("arst_gray",  bus.rd_ptr_gray,  0);
        chk("arst_valid", bus.rd_valid,     0);
        chk("arst_data",  bus.rd_data,      0);
        chk("arst_empty", bus.empty,        1);
        chk("arst_level", bus.rd_level,     0);
        chk("arst_ae",    bus.almost_empty, 1);
        chk("arst_uf",    bus.underflow,    0);
        wr_count = 0;
        order_q.delete();
        #2 rd_rst = 1'b0;
        tick();

        // Stream 40 words through the wrap
        written    = 0;
        got        = 0;
        addr_wraps = 0;
        ptr_wraps  = 0;
        prev_addr  = bus.rd_addr;
        prev_ptr   = bus.rd_ptr;
        bus.rd_en  = 1'b1;
        for (int c = 0; c < 400 && got < 40; c++) begin
            if (written < 40 && (wr_count - m_rd) < DEPTH) begin
                wr_word(8'h40 + 8'(written));
                written++;
            end
            tick();
            if (bus.rd_valid) got++;
            if (prev_addr == DEPTH - 1 && bus.rd_addr == 0) addr_wraps++;
            if (prev_ptr == 2 * DEPTH - 1 && bus.rd_ptr == 0) ptr_wraps++;
            prev_addr = bus.rd_addr;
            prev_ptr  = bus.rd_ptr;
        end
        bus.rd_en = 1'b0;
        $display("stream: got=%0d addr_wraps=%0d ptr_wraps=%0d rd_ptr=%0d", got, addr_wraps, ptr_wraps, bus.rd_ptr);
        chk("stream_count",      got,        40);
        chk("stream_addr_wraps", addr_wraps, 2);
        chk("stream_ptr_wraps",  ptr_wraps,  1);
        chk("stream_end_ptr",    bus.rd_ptr, 8);
        repeat (2) tick();

        // Full FIFO drained with rd_en held
        for (int i = 0; i < DEPTH; i++) wr_word(8'h80 + 8'(i));
        repeat (4) tick();
        chk("full_level", bus.rd_level,     16);
        chk("full_ae",    bus.almost_empty, 0);
        chk("full_empty", bus.empty,        0);
        vcount    = 0;
        bus.rd_en = 1'b1;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            tick();
            if (bus.rd_valid) vcount++;
            $display("drain cycle %0d: valid=%0d empty=%0d underflow=%0d", k, bus.rd_valid, bus.empty, bus.underflow);
            if (k == DEPTH - 1) chk("drain15_empty", bus.empty, 0);
            if (k == DEPTH) begin
                chk("drain16_empty", bus.empty,    1);
                chk("drain16_valid", bus.rd_valid, 1);
            end
            if (k == DEPTH + 1) begin
                chk("drain17_uf",    bus.underflow, 1);
                chk("drain17_valid", bus.rd_valid,  0);
            end
        end
        bus.rd_en = 1'b0;
        chk("drain_valid_count", vcount, 16);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
